// File: rtl/number_stream_tx_pkg.sv
// Shared definitions for the number_stream_tx producer: data width, LFSR taps,
// default run sizes and the FSM state encoding.
package number_stream_tx_pkg;

    localparam int DATA_W          = 8;
    localparam int DEF_NUM_WORDS   = 20;
    localparam int DEF_TIMEOUT     = 64;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a left-shifting register
    localparam logic [DATA_W-1:0] LFSR_TAPS = 8'hB8;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t CLEAR = 3'd1;
    localparam state_t SEND  = 3'd2;
    localparam state_t FLUSH = 3'd3;
    localparam state_t CHECK = 3'd4;

    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] cur);
        return {cur[DATA_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/numb_word_gen.sv
// Data word source for number_stream_tx: incrementing pattern by default,
// 8-bit Fibonacci LFSR when NUMB_TX_LFSR_EN is defined.
module numb_word_gen
    import number_stream_tx_pkg::*;
(
    input  logic              CLK,
    input  logic              RESETZ,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  logic              adv,
    output logic [DATA_W-1:0] word
);

`ifdef NUMB_TX_LFSR_EN
    // An all-zero LFSR never leaves zero, so a zero seed starts at 8'h01
    always_ff @(posedge CLK or posedge RESETZ) begin
        if (RESETZ) begin
            word <= '0;
        end else if (load) begin
            word <= (seed == '0) ? 8'h01 : seed;
        end else if (adv) begin
            word <= lfsr_next(word);
        end
    end
`else
    always_ff @(posedge CLK or posedge RESETZ) begin
        if (RESETZ) begin
            word <= '0;
        end else if (load) begin
            word <= seed;
        end else if (adv) begin
            word <= word + 8'd1;
        end
    end
`endif

endmodule

// File: rtl/number_stream_tx.sv
// Producer end of the valid/numb max-finder stream: clears the receiver, sends
// NUM_WORDS words, flushes with zeros until Q and checks the reported max.
// Optional LFSR word pattern selected with NUMB_TX_LFSR_EN (see numb_word_gen).
module number_stream_tx
    import number_stream_tx_pkg::*;
#(
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic              CLK,
    input  logic              RESETZ,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    input  logic              stall,
    input  logic              q_in,
    input  logic [DATA_W-1:0] maxnumb_in,
    output logic              rx_rst,
    output logic              valid,
    output logic [DATA_W-1:0] numb,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [DATA_W-1:0] exp_max
);

    localparam logic [7:0]  LAST_IDX = 8'(NUM_WORDS - 1);
    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

    state_t            state;
    logic [7:0]        idx;
    logic [15:0]       fcnt;
    logic [DATA_W-1:0] word;
    logic              accept;
    logic              emit;

    assign accept = (state == IDLE) && start;
    assign emit   = (state == SEND) && !stall;

    numb_word_gen u_gen (
        .CLK    (CLK),
        .RESETZ (RESETZ),
        .load   (accept),
        .seed   (seed),
        .adv    (emit),
        .word   (word)
    );

    // Stream-side outputs follow state and stall in the same cycle
    assign rx_rst = (state == CLEAR);
    assign valid  = ((state == SEND) || (state == FLUSH)) && !stall;
    assign numb   = (state == SEND) ? word : '0;
    assign busy   = (state != IDLE);
    assign done   = (state == CHECK);

    always_ff @(posedge CLK or posedge RESETZ) begin
        if (RESETZ) begin
            state   <= IDLE;
            idx     <= '0;
            fcnt    <= '0;
            exp_max <= '0;
            pass    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CLEAR;
                        idx     <= '0;
                        exp_max <= '0;
                        pass    <= 1'b0;
                        timeout <= 1'b0;
                    end
                end
                CLEAR: begin
                    state <= SEND;
                end
                SEND: begin
                    if (!stall) begin
                        if (word > exp_max) begin
                            exp_max <= word;
                        end
                        idx <= idx + 8'd1;
                        if (idx == LAST_IDX) begin
                            state <= FLUSH;
                            fcnt  <= '0;
                        end
                    end
                end
                // A receiver answer wins over an expiring wait in the same cycle
                FLUSH: begin
                    if (q_in) begin
                        state <= CHECK;
                    end else if (fcnt == LAST_CNT) begin
                        state   <= CHECK;
                        timeout <= 1'b1;
                    end else begin
                        fcnt <= fcnt + 16'd1;
                    end
                end
                CHECK: begin
                    pass  <= !timeout && (maxnumb_in == exp_max);
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_number_stream_tx.sv
// Directed self-checking bench for number_stream_tx with a behavioural
// max-finder receiver; LFSR scenario enabled with NUMB_TX_LFSR_EN.
module tb_number_stream_tx;

    localparam int NW = 20;
    localparam int TO = 64;

    logic       CLK    = 1'b0;
    logic       RESETZ = 1'b1;
    logic       start  = 1'b0;
    logic [7:0] seed   = 8'h00;
    logic       stall  = 1'b0;
    logic       q_in;
    logic [7:0] maxnumb_in;
    logic       rx_rst, valid, busy, done, pass, timeout;
    logic [7:0] numb, exp_max;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 CLK = ~CLK;

    number_stream_tx #(.NUM_WORDS(NW), .TIMEOUT(TO)) dut (
        .CLK        (CLK),
        .RESETZ     (RESETZ),
        .start      (start),
        .seed       (seed),
        .stall      (stall),
        .q_in       (q_in),
        .maxnumb_in (maxnumb_in),
        .rx_rst     (rx_rst),
        .valid      (valid),
        .numb       (numb),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .timeout    (timeout),
        .exp_max    (exp_max)
    );

    // Behavioural receiver: tracks max, raises Q once a word beyond the data arrives
    logic [7:0] rxMax   = 8'h00;
    int         rxCount = 0;
    logic       rxQ     = 1'b0;
    logic       forceQLow = 1'b0;
    logic       forceMax  = 1'b0;
    logic [7:0] forcedMax = 8'h00;

    always @(posedge CLK) begin
        if (rx_rst) begin
            rxMax   <= 8'h00;
            rxCount <= 0;
            rxQ     <= 1'b0;
        end else if (valid) begin
            if (numb > rxMax) rxMax <= numb;
            if (rxCount >= NW) rxQ <= 1'b1;
            rxCount <= rxCount + 1;
        end
    end

    assign q_in       = rxQ && !forceQLow;
    assign maxnumb_in = forceMax ? forcedMax : rxMax;

    logic [7:0] got [NW];
    int         gotN, firstValid, doneCycles;
    logic       stallValid, sawDone, nonzeroFlush;
    logic       doneTimeout, donePass, doneBusy;
    logic [7:0] doneExp;

    function automatic logic [7:0] refWord(input logic [7:0] s, input int i);
        logic [7:0] w;
`ifdef NUMB_TX_LFSR_EN
        w = (s == 8'h00) ? 8'h01 : s;
        for (int k = 0; k < i; k++) w = {w[6:0], w[7] ^ w[5] ^ w[4] ^ w[3]};
`else
        w = s + 8'(i);
`endif
        return w;
    endfunction

    function automatic logic [7:0] refMax(input logic [7:0] s);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < NW; i++) if (refWord(s, i) > m) m = refWord(s, i);
        return m;
    endfunction

    function automatic int seqErrors(input logic [7:0] s);
        int e;
        e = 0;
        for (int i = 0; i < NW; i++) if (got[i] !== refWord(s, i)) e++;
        return e;
    endfunction

    task automatic startRun(input logic [7:0] s);
        @(negedge CLK);
        seed  = s;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        seed  = 8'h55;
    endtask

    task automatic collectWords(input logic altStall, input int budget);
        int cyc;
        cyc = 0; gotN = 0; firstValid = -1; stallValid = 1'b0;
        while (gotN < NW && cyc < budget) begin
            @(negedge CLK);
            stall = altStall && cyc[0];
            #1;
            if (stall && valid) stallValid = 1'b1;
            if (valid) begin
                if (firstValid < 0) firstValid = cyc;
                got[gotN] = numb;
                gotN++;
            end
            cyc++;
        end
        stall = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        sawDone = 1'b0; doneCycles = 0; nonzeroFlush = 1'b0;
        while (!sawDone && doneCycles < budget) begin
            @(negedge CLK);
            #1;
            doneCycles++;
            if (valid && numb !== 8'h00) nonzeroFlush = 1'b1;
            if (done) begin
                sawDone     = 1'b1;
                doneTimeout = timeout;
                doneExp     = exp_max;
            end
        end
        if (sawDone) begin
            @(negedge CLK);
            #1;
            donePass = pass;
            doneBusy = busy;
        end
    endtask

    task automatic test_reset;
        @(negedge CLK);
        #1;
        testsRun++;
        if ({rx_rst, valid, numb, busy, done, pass, timeout, exp_max} !== 22'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got %h, expected 0",
                     {rx_rst, valid, numb, busy, done, pass, timeout, exp_max});
        end
        RESETZ = 1'b0;
        @(negedge CLK);
        #1;
        testsRun++;
        if (busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL idle_after_reset: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_incrementing;
        startRun(8'd10);
        testsRun++;
        if (rx_rst !== 1'b1 || valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL clear_cycle: rx_rst=%b valid=%b, expected 1 0", rx_rst, valid);
        end
        collectWords(1'b0, 60);
        testsRun++;
        if (gotN !== NW || firstValid !== 0) begin
            testsFailed++;
            $display("[TB] FAIL incr_count: words=%0d first=%0d, expected %0d 0", gotN, firstValid, NW);
        end
        testsRun++;
        if (got[0] !== 8'd10 || got[NW-1] !== 8'd29 || seqErrors(8'd10) != 0) begin
            testsFailed++;
            $display("[TB] FAIL incr_seq: first=%0d last=%0d errors=%0d, expected 10 29 0",
                     got[0], got[NW-1], seqErrors(8'd10));
        end
        waitDone(100);
        testsRun++;
        if (!sawDone || doneCycles !== 3 || nonzeroFlush) begin
            testsFailed++;
            $display("[TB] FAIL incr_flush: done=%b cycles=%0d nonzero=%b, expected 1 3 0",
                     sawDone, doneCycles, nonzeroFlush);
        end
        testsRun++;
        if (doneExp !== 8'd29 || donePass !== 1'b1 || doneTimeout !== 1'b0 || doneBusy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL incr_result: exp_max=%0d pass=%b timeout=%b busy=%b, expected 29 1 0 0",
                     doneExp, donePass, doneTimeout, doneBusy);
        end
    endtask

    task automatic test_wrap;
        startRun(8'hF0);
        collectWords(1'b0, 60);
        testsRun++;
        if (gotN !== NW || got[15] !== 8'hFF || got[16] !== 8'h00 || got[NW-1] !== 8'h03) begin
            testsFailed++;
            $display("[TB] FAIL wrap_seq: words=%0d w15=%h w16=%h last=%h, expected 20 ff 00 03",
                     gotN, got[15], got[16], got[NW-1]);
        end
        waitDone(100);
        testsRun++;
        if (!sawDone || doneExp !== 8'hFF || donePass !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL wrap_max: done=%b exp_max=%h pass=%b, expected 1 ff 1",
                     sawDone, doneExp, donePass);
        end
    endtask

    task automatic test_bad_max;
        forceMax  = 1'b1;
        forcedMax = 8'd28;
        startRun(8'd10);
        collectWords(1'b0, 60);
        waitDone(100);
        testsRun++;
        if (!sawDone || donePass !== 1'b0 || doneTimeout !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL bad_max: done=%b pass=%b timeout=%b, expected 1 0 0",
                     sawDone, donePass, doneTimeout);
        end
        forceMax = 1'b0;
    endtask

    task automatic test_stall;
        startRun(8'd10);
        collectWords(1'b1, 100);
        testsRun++;
        if (gotN !== NW || stallValid !== 1'b0 || seqErrors(8'd10) != 0) begin
            testsFailed++;
            $display("[TB] FAIL stall_seq: words=%0d valid_on_stall=%b errors=%0d, expected %0d 0 0",
                     gotN, stallValid, seqErrors(8'd10), NW);
        end
        waitDone(100);
        testsRun++;
        if (!sawDone || doneExp !== refMax(8'd10) || donePass !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL stall_result: done=%b exp_max=%h pass=%b, expected 1 %h 1",
                     sawDone, doneExp, donePass, refMax(8'd10));
        end
    endtask

    task automatic test_timeout;
        forceQLow = 1'b1;
        startRun(8'd7);
        collectWords(1'b0, 60);
        waitDone(200);
        testsRun++;
        if (!sawDone || doneCycles !== TO + 1 || doneTimeout !== 1'b1 || donePass !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL timeout_run: done=%b cycles=%0d timeout=%b pass=%b, expected 1 %0d 1 0",
                     sawDone, doneCycles, doneTimeout, donePass, TO + 1);
        end
        forceQLow = 1'b0;
        startRun(8'd7);
        testsRun++;
        if (timeout !== 1'b0 || pass !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL timeout_clear: timeout=%b pass=%b, expected 0 0", timeout, pass);
        end
        collectWords(1'b0, 60);
        waitDone(100);
        testsRun++;
        if (!sawDone || donePass !== 1'b1 || doneTimeout !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL timeout_recover: done=%b pass=%b timeout=%b, expected 1 1 0",
                     sawDone, donePass, doneTimeout);
        end
    endtask

    task automatic test_reset_midrun;
        logic sawLate;
        startRun(8'd10);
        repeat (5) @(negedge CLK);
        RESETZ = 1'b1;
        #1;
        testsRun++;
        if ({rx_rst, valid, numb, busy, done, pass, timeout, exp_max} !== 22'd0) begin
            testsFailed++;
            $display("[TB] FAIL midrun_reset: got %h, expected 0",
                     {rx_rst, valid, numb, busy, done, pass, timeout, exp_max});
        end
        @(negedge CLK);
        RESETZ  = 1'b0;
        sawLate = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            #1;
            if (done || busy || valid) sawLate = 1'b1;
        end
        testsRun++;
        if (sawLate !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midrun_quiet: activity=%b, expected 0", sawLate);
        end
        startRun(8'h33);
        testsRun++;
        if (rx_rst !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL restart_clear: rx_rst=%b, expected 1", rx_rst);
        end
        collectWords(1'b0, 60);
        testsRun++;
        if (gotN !== NW || seqErrors(8'h33) != 0) begin
            testsFailed++;
            $display("[TB] FAIL restart_seq: words=%0d first=%h errors=%0d, expected %0d %h 0",
                     gotN, got[0], seqErrors(8'h33), NW, refWord(8'h33, 0));
        end
        waitDone(100);
        testsRun++;
        if (!sawDone || donePass !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL restart_result: done=%b pass=%b, expected 1 1", sawDone, donePass);
        end
    endtask

`ifdef NUMB_TX_LFSR_EN
    task automatic test_lfsr;
        startRun(8'h00);
        collectWords(1'b0, 60);
        testsRun++;
        if (gotN !== NW || got[0] !== 8'h01 || got[1] !== 8'h02 || seqErrors(8'h00) != 0) begin
            testsFailed++;
            $display("[TB] FAIL lfsr_seq: words=%0d w0=%h w1=%h errors=%0d, expected %0d 01 02 0",
                     gotN, got[0], got[1], seqErrors(8'h00), NW);
        end
        waitDone(100);
        testsRun++;
        if (!sawDone || doneExp !== refMax(8'h00) || donePass !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL lfsr_result: done=%b exp_max=%h pass=%b, expected 1 %h 1",
                     sawDone, doneExp, donePass, refMax(8'h00));
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef NUMB_TX_LFSR_EN
        test_lfsr();
`else
        test_incrementing();
        test_wrap();
        test_bad_max();
`endif
        test_stall();
        test_timeout();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
